// File: rtl/dm_store_buffer.sv
// dm_store_buffer: in-order store queue between the MEM stage and data memory.
// Stores are buffered and drained through a valid/ready write port. Loads are
// answered combinationally, forwarding from the youngest buffered store to the
// same doubleword, else from memory read data.
//
// Drain handshake: mem_wr_valid/mem_wr_addr/mem_wr_data describe the head entry.
// A transfer happens at a rising edge where mem_wr_valid && mem_wr_ready. While
// valid is high and ready is low, addr/data hold steady. Valid only falls after
// a transfer empties the buffer, or on reset.
module dm_store_buffer #(
  parameter int N     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] DM_addr,
  input  logic [N-1:0] DM_writeData,
  input  logic         DM_writeEnable,
  input  logic         DM_readEnable,
  output logic [N-1:0] DM_readData,
  output logic [N-1:0] mem_rd_addr,
  input  logic [N-1:0] mem_rd_data,
  output logic         mem_wr_valid,
  output logic [N-1:0] mem_wr_addr,
  output logic [N-1:0] mem_wr_data,
  input  logic         mem_wr_ready,
  output logic         sb_full,
  output logic         sb_empty,
  output logic         sb_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = N - 3;

  // Entry storage: doubleword address and data.
  logic [AW-1:0] entryAddr [DEPTH];
  logic [N-1:0]  entryData [DEPTH];

  // Pointers and count carry one extra bit.
  logic [CW-1:0] rdPtr;
  logic [CW-1:0] wrPtr;
  logic [CW-1:0] count;
  logic [PW-1:0] rdIdx;
  logic [PW-1:0] wrIdx;

  logic          enq;
  logic          deq;
  logic          overflowReg;

  logic          fwdHit;
  logic [N-1:0]  fwdData;
  logic [PW-1:0] slot;

  // Load-enable is informational only; the datapath ignores the result when idle.
  logic          unusedReadEnable;
  assign unusedReadEnable = DM_readEnable;

  assign rdIdx = rdPtr[PW-1:0];
  assign wrIdx = wrPtr[PW-1:0];

  assign sb_empty     = (count == '0);
  assign sb_full      = (count == CW'(DEPTH));
  assign sb_overflow  = overflowReg;

  assign mem_wr_valid = !sb_empty;
  assign mem_wr_addr  = {entryAddr[rdIdx], 3'b000};
  assign mem_wr_data  = entryData[rdIdx];
  assign mem_rd_addr  = DM_addr;

  // A full buffer still accepts a store when the head drains at the same edge.
  assign deq = mem_wr_valid && mem_wr_ready;
  assign enq = DM_writeEnable && (!sb_full || deq);

  // Queue state: entries, pointers, count and the sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entryAddr[i] <= '0;
        entryData[i] <= '0;
      end
      rdPtr       <= '0;
      wrPtr       <= '0;
      count       <= '0;
      overflowReg <= 1'b0;
    end else begin
      if (enq) begin
        entryAddr[wrIdx] <= DM_addr[N-1:3];
        entryData[wrIdx] <= DM_writeData;
        wrPtr            <= wrPtr + CW'(1);
      end
      if (deq) begin
        rdPtr <= rdPtr + CW'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (DM_writeEnable && !enq) begin
        overflowReg <= 1'b1;
      end
    end
  end

  // Forwarding search from oldest to youngest; the last match wins. The head
  // is included even in the cycle it drains, since state changes only at the edge.
  always_comb begin
    fwdHit  = 1'b0;
    fwdData = '0;
    slot    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = rdIdx + PW'(i);
      if ((CW'(i) < count) && (entryAddr[slot] == DM_addr[N-1:3])) begin
        fwdHit  = 1'b1;
        fwdData = entryData[slot];
      end
    end
  end

  // Load result: buffered data when a store to the doubleword is pending.
  assign DM_readData = fwdHit ? fwdData : mem_rd_data;

endmodule

// File: tb/tb_dm_store_buffer.sv
// tb_dm_store_buffer: directed test of dm_store_buffer with a drain scoreboard.
module tb_dm_store_buffer;

  localparam int N = 64;
  localparam logic [N-1:0] RD_KEY = 64'hF0F0_5A5A_C3C3_9696;

  // ---------------- clock / reset ----------------
  logic         clk;
  logic         reset;
  logic [N-1:0] dmAddr;
  logic [N-1:0] dmWriteData;
  logic         dmWriteEnable;
  logic         dmReadEnable;
  logic [N-1:0] dmReadData;
  logic [N-1:0] memRdAddr;
  logic [N-1:0] memRdData;
  logic         memWrValid;
  logic [N-1:0] memWrAddr;
  logic [N-1:0] memWrData;
  logic         memWrReady;
  logic         sbFull;
  logic         sbEmpty;
  logic         sbOverflow;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory read data model: a fixed function of the bench's own address.
  assign memRdData = dmAddr ^ RD_KEY;

  dm_store_buffer #(.N(N), .DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .DM_addr       (dmAddr),
    .DM_writeData  (dmWriteData),
    .DM_writeEnable(dmWriteEnable),
    .DM_readEnable (dmReadEnable),
    .DM_readData   (dmReadData),
    .mem_rd_addr   (memRdAddr),
    .mem_rd_data   (memRdData),
    .mem_wr_valid  (memWrValid),
    .mem_wr_addr   (memWrAddr),
    .mem_wr_data   (memWrData),
    .mem_wr_ready  (memWrReady),
    .sb_full       (sbFull),
    .sb_empty      (sbEmpty),
    .sb_overflow   (sbOverflow)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [2*N-1:0] exp_q[$];

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  logic         prevHold = 1'b0;
  logic [N-1:0] prevAddr = '0;
  logic [N-1:0] prevData = '0;

  // Negedge monitor: a handshake seen here commits at the next rising edge.
  always @(negedge clk) begin
    if (reset) begin
      prevHold = 1'b0;
    end else begin
      if (prevHold) begin
        check("hold_valid", {63'd0, memWrValid}, 64'd1);
        check("hold_addr", memWrAddr, prevAddr);
        check("hold_data", memWrData, prevData);
      end
      if (memWrValid && memWrReady) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", memWrAddr, 64'hXXXX_XXXX_XXXX_XXXX);
        end else begin
          logic [2*N-1:0] e;
          e = exp_q.pop_front();
          check("drain_addr", memWrAddr, e[2*N-1:N]);
          check("drain_data", memWrData, e[N-1:0]);
        end
      end
      prevHold = memWrValid && !memWrReady;
      prevAddr = memWrAddr;
      prevData = memWrData;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [N-1:0] a, input logic [N-1:0] d, input bit accepted);
    dmAddr        = a;
    dmWriteData   = d;
    dmWriteEnable = 1'b1;
    if (accepted) exp_q.push_back({a & ~64'd7, d});
    tick();
    dmWriteEnable = 1'b0;
  endtask

  task automatic load(input string tag, input logic [N-1:0] a, input logic [N-1:0] exp);
    dmAddr       = a;
    dmReadEnable = 1'b1;
    #1;
    check(tag, dmReadData, exp);
    check("rd_addr_pass", memRdAddr, a);
    dmReadEnable = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    dmAddr = '0; dmWriteData = '0; dmWriteEnable = 1'b0; dmReadEnable = 1'b0;
    memWrReady = 1'b0;
    #2;
    check("rst_empty", {63'd0, sbEmpty}, 64'd1);
    check("rst_full", {63'd0, sbFull}, 64'd0);
    check("rst_valid", {63'd0, memWrValid}, 64'd0);
    check("rst_ovf", {63'd0, sbOverflow}, 64'd0);
    check("rst_waddr", memWrAddr, 64'd0);
    check("rst_wdata", memWrData, 64'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Basic drain
    store(64'h10, 64'hAAAA, 1);
    check("basic_valid", {63'd0, memWrValid}, 64'd1);
    check("basic_addr", memWrAddr, 64'h10);
    check("basic_data", memWrData, 64'hAAAA);
    check("basic_empty", {63'd0, sbEmpty}, 64'd0);
    tick();
    memWrReady = 1'b1;
    tick();
    memWrReady = 1'b0;
    check("basic_empty_after", {63'd0, sbEmpty}, 64'd1);

    // Forwarding, youngest wins; same-cycle store sees pre-edge data
    store(64'h20, 64'd1, 1);
    store(64'h20, 64'd2, 1);
    load("fwd_young", 64'h20, 64'd2);
    load("fwd_miss", 64'h28, 64'h28 ^ RD_KEY);
    load("fwd_lowbits", 64'h23, 64'd2);
    dmWriteData = 64'd3; dmWriteEnable = 1'b1;
    load("fwd_pre_edge", 64'h20, 64'd2);
    exp_q.push_back({64'h20, 64'd3});
    tick();
    dmWriteEnable = 1'b0;
    load("fwd_new", 64'h20, 64'd3);
    memWrReady = 1'b1;
    load("fwd_during_drain", 64'h20, 64'd3);
    repeat (3) tick();
    memWrReady = 1'b0;
    check("fwd_drained", {63'd0, sbEmpty}, 64'd1);
    load("fwd_after_drain", 64'h20, 64'h20 ^ RD_KEY);

    // Fill and overflow
    for (int i = 0; i < 4; i++) store(64'h100 + 64'(8 * i), 64'h1000 + 64'(i), 1);
    check("fill_full", {63'd0, sbFull}, 64'd1);
    check("fill_ovf0", {63'd0, sbOverflow}, 64'd0);
    store(64'h200, 64'hBAD, 0);
    check("ovf_set", {63'd0, sbOverflow}, 64'd1);
    check("ovf_full", {63'd0, sbFull}, 64'd1);
    memWrReady = 1'b1;
    repeat (4) tick();
    memWrReady = 1'b0;
    check("ovf_drained", {63'd0, sbEmpty}, 64'd1);
    check("ovf_sticky", {63'd0, sbOverflow}, 64'd1);
    tick();
    check("ovf_still", {63'd0, sbOverflow}, 64'd1);

    // Full with simultaneous enqueue and dequeue
    pulse_reset();
    check("ovf_cleared", {63'd0, sbOverflow}, 64'd0);
    for (int i = 0; i < 4; i++) store(64'h300 + 64'(8 * i), 64'h3000 + 64'(i), 1);
    check("simul_full_before", {63'd0, sbFull}, 64'd1);
    memWrReady = 1'b1;
    store(64'h340, 64'h55, 1);
    memWrReady = 1'b0;
    check("simul_full_after", {63'd0, sbFull}, 64'd1);
    check("simul_ovf", {63'd0, sbOverflow}, 64'd0);
    check("simul_head", memWrAddr, 64'h308);
    memWrReady = 1'b1;
    repeat (4) tick();
    memWrReady = 1'b0;
    check("simul_drained", {63'd0, sbEmpty}, 64'd1);

    // Wrap with ready toggling
    for (int i = 0; i < 20; i++) begin
      memWrReady = ((i % 4) >= 2);
      if (i % 2 == 0) begin
        store(64'h400 + 64'(8 * (i / 2)), {$urandom, $urandom}, 1);
      end else begin
        tick();
      end
    end
    memWrReady = 1'b1;
    for (int k = 0; k < 20 && !sbEmpty; k++) tick();
    memWrReady = 1'b0;
    check("wrap_drained", {63'd0, sbEmpty}, 64'd1);
    check("wrap_ovf", {63'd0, sbOverflow}, 64'd0);

    // Reset mid-drain
    for (int i = 0; i < 3; i++) store(64'h500 + 64'(8 * i), 64'h5000 + 64'(i), 0);
    check("mid_valid_before", {63'd0, memWrValid}, 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_valid", {63'd0, memWrValid}, 64'd0);
    check("mid_empty", {63'd0, sbEmpty}, 64'd1);
    check("mid_full", {63'd0, sbFull}, 64'd0);
    check("mid_waddr", memWrAddr, 64'd0);
    check("mid_wdata", memWrData, 64'd0);
    tick();
    reset = 1'b0;
    memWrReady = 1'b1;
    repeat (5) tick();
    memWrReady = 1'b0;
    check("mid_empty_after", {63'd0, sbEmpty}, 64'd1);

    tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_store_buffer.md
# dm_store_buffer

Store buffer between the pipelined datapath's memory-stage data ports and the external data memory. Stores issued by the MEM stage are queued in a small in-order FIFO and drained to memory through a valid/ready write port. Loads are answered combinationally in the same cycle, with store-to-load forwarding from the youngest matching buffered store. `sb_full` feeds the hazard unit, which stalls the pipeline before a store can be lost.

## Interface
- `N`, 64, data/address width.
- `DEPTH`, 4, number of buffer entries; power of two, ≥2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `DM_addr` in N: MEM-stage byte address; doubleword aligned, bits [2:0] ignored.
- `DM_writeData` in N: store data.
- `DM_writeEnable` in 1: store request this cycle.
- `DM_readEnable` in 1: load request this cycle.
- `DM_readData` out N: load result, combinational.
- `mem_rd_addr` out N: equals `DM_addr` at all times.
- `mem_rd_data` in N: combinational read data from memory.
- `mem_wr_valid` out 1: head entry valid for drain.
- `mem_wr_addr` out N: head entry address.
- `mem_wr_data` out N: head entry data.
- `mem_wr_ready` in 1: memory accepts the write at this edge.
- `sb_full` out 1: count == DEPTH.
- `sb_empty` out 1: count == 0.
- `sb_overflow` out 1: sticky; a store was dropped.

## Operation
- **Storage:** DEPTH entries of {addr[N-1:3], data}.
  - Read pointer, write pointer and count, each log2(DEPTH)+1 bits.
  - Pointers wrap modulo DEPTH.
- **Enqueue:** at an edge with `DM_writeEnable` = 1 and a free slot.
  - Write the entry at the write pointer, then increment it.
  - A slot is free when count < DEPTH, or when count == DEPTH and a dequeue occurs at the same edge.
- **Dequeue:** at an edge with `mem_wr_valid` && `mem_wr_ready`; increment the read pointer.
  - `mem_wr_valid` = !`sb_empty`.
  - `mem_wr_addr` = {head.addr, 3'b000}.
  - `mem_wr_data` = head.data.
- **Count update:**
  - +1 on enqueue only.
  - −1 on dequeue only.
  - Unchanged on both or neither.
- **Overflow:** a store that finds no free slot is discarded, not enqueued.
  - `sb_overflow` is set and holds until reset.
- **Load forwarding:**
  - `DM_readData` = data of the youngest valid entry whose addr equals `DM_addr[N-1:3]`; otherwise `mem_rd_data`.
  - "Youngest" means closest to the write pointer.
  - The forwarding search includes the head entry in the same cycle it is being dequeued.
  - The output is computed regardless of `DM_readEnable`; the datapath ignores it when no load is active.
- **Simultaneous load and store, same cycle:** the load sees pre-edge buffer contents. It never returns the data it is storing.
- **Drain order:** strictly FIFO.
  - Two stores to the same address both drain, in order.
  - No merging.
- **Drain handshake:** while `mem_wr_valid` is high and `mem_wr_ready` low, head addr and data stay stable.
  - `mem_wr_valid` never drops without a transfer, except on reset.

## Timing
- **Reset (asynchronous, immediate):**
  - Pointers and count are cleared.
  - `sb_empty` = 1, `sb_full` = 0, `mem_wr_valid` = 0, `sb_overflow` = 0.
  - `mem_wr_addr` and `mem_wr_data` = 0; entry storage is cleared.
  - Buffered stores are discarded; reset mid-drain aborts with no further write.
- **Store latency:** a store sampled at edge k is forwardable and drain-eligible in cycle k+1.
  - Earliest memory commit is edge k+1, when `mem_wr_ready` = 1.
- **Throughput:** one enqueue and one dequeue per cycle.
  - Full with a continuous `mem_wr_ready` sustains one store per cycle without overflow.
- **Flags:** `sb_full` and `sb_empty` are registered-state decodes; they update the cycle after the edge.
- **Hazard stall timing:** `sb_full` must be observed by the hazard unit one cycle before a store reaches MEM, or that store is dropped.

## Test plan
- **Basic drain:** reset; store 0xAAAA at addr 0x10 with `mem_wr_ready` = 0.
  - Next cycle: `mem_wr_valid` = 1, `mem_wr_addr` = 0x10, `sb_empty` = 0.
  - Raise ready: one write of 0xAAAA, then `sb_empty` = 1.
- **Forwarding, youngest wins:** with ready = 0, store 1 then 2 to 0x20, then load 0x20 → `DM_readData` = 2.
  - Load 0x28 → `mem_rd_data`.
  - Load 0x23 → 2, since bits [2:0] are ignored.
- **Fill and overflow:** ready = 0; 4 stores → `sb_full` = 1.
  - A 5th store is dropped and `sb_overflow` = 1.
  - Drain yields exactly the first 4 values, in order.
- **Full with simultaneous enqueue and dequeue:** full, ready = 1, new store 0x55 → accepted, count stays 4, `sb_overflow` stays 0.
- **Wrap and stability:**
  - 10 stores with ready toggling every other cycle: pointers wrap, drain order matches issue order.
  - Head addr/data are stable during every ready = 0 cycle.
- **Reset mid-drain:** 3 entries buffered, assert `reset` asynchronously between edges.
  - Immediately `mem_wr_valid` = 0 and `sb_empty` = 1.
  - No writes after release.
